// File: rtl/vga_timing_gen_if.sv
// Raster interface between the VGA timing generator and its consumers
// (stacker block controller and the VGA pins).
interface vga_timing_gen_if;
  logic       pclk_en;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       hSync;
  logic       vSync;
  logic       bright;
  logic       frame_tick;
  logic       game_tick;

  modport master (
    output pclk_en, hCount, vCount, hSync, vSync, bright, frame_tick, game_tick
  );

  modport slave (
    input pclk_en, hCount, vCount, hSync, vSync, bright, frame_tick, game_tick
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA 640x480@60Hz timing generator. Divides the board clock down to a
// pixel enable, walks the raster position, and produces sync, active-video,
// a per-frame tick and a slower game tick used to pace sprite movement.
module vga_timing_gen #(
  parameter int CLK_DIV         = 4,
  parameter int H_TOTAL         = 800,
  parameter int H_SYNC          = 96,
  parameter int H_ACT_START     = 144,
  parameter int H_ACT_END       = 784,
  parameter int V_TOTAL         = 525,
  parameter int V_SYNC          = 2,
  parameter int V_ACT_START     = 35,
  parameter int V_ACT_END       = 515,
  parameter int FRAMES_PER_TICK = 6
) (
  input  logic               clk,
  input  logic               rst,
  vga_timing_gen_if.master   vga
);

  localparam logic [9:0] DIV_LAST  = 10'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_S_W = 10'(H_ACT_START);
  localparam logic [9:0] H_ACT_E_W = 10'(H_ACT_END);
  localparam logic [9:0] V_ACT_S_W = 10'(V_ACT_START);
  localparam logic [9:0] V_ACT_E_W = 10'(V_ACT_END);
  localparam logic [9:0] FPT_LAST  = 10'(FRAMES_PER_TICK - 1);

  logic [9:0] div_cnt;
  logic [9:0] frame_cnt;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       frame_wrap;

  // Next raster position; sync and bright are derived from it so they line up with the counts.
  always_comb begin
    h_next     = vga.hCount;
    v_next     = vga.vCount;
    frame_wrap = 1'b0;
    if (vga.pclk_en) begin
      if (vga.hCount == H_LAST) begin
        h_next = 10'd0;
        if (vga.vCount == V_LAST) begin
          v_next     = 10'd0;
          frame_wrap = 1'b1;
        end else begin
          v_next = vga.vCount + 10'd1;
        end
      end else begin
        h_next = vga.hCount + 10'd1;
      end
    end
  end

  // Clock divider producing a registered one-clock pixel enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt     <= 10'd0;
      vga.pclk_en <= 1'b0;
    end else begin
      vga.pclk_en <= (div_cnt == DIV_LAST);
      div_cnt     <= (div_cnt == DIV_LAST) ? 10'd0 : div_cnt + 10'd1;
    end
  end

  // Raster counters with sync and active-video registered alongside them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga.hCount <= 10'd0;
      vga.vCount <= 10'd0;
      vga.hSync  <= 1'b0;
      vga.vSync  <= 1'b0;
      vga.bright <= 1'b0;
    end else begin
      vga.hCount <= h_next;
      vga.vCount <= v_next;
      vga.hSync  <= (h_next >= H_SYNC_W);
      vga.vSync  <= (v_next >= V_SYNC_W);
      vga.bright <= (h_next >= H_ACT_S_W) && (h_next < H_ACT_E_W) &&
                    (v_next >= V_ACT_S_W) && (v_next < V_ACT_E_W);
    end
  end

  // Frame tick on the wrap to (0,0); game tick when the frame counter wraps too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt      <= 10'd0;
      vga.frame_tick <= 1'b0;
      vga.game_tick  <= 1'b0;
    end else begin
      vga.frame_tick <= frame_wrap;
      vga.game_tick  <= frame_wrap && (frame_cnt == FPT_LAST);
      if (frame_wrap) begin
        frame_cnt <= (frame_cnt == FPT_LAST) ? 10'd0 : frame_cnt + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for the line timing, a
// shrunken-raster instance for window, frame and game ticks and mid-run reset,
// and a single-frame-per-tick instance where game_tick must follow frame_tick.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rstA = 1'b1;
  logic rstB = 1'b1;

  int total = 0;
  int bad   = 0;

  int nA = 0;
  int nB = 0;

  int        ftCount   = 0;
  int        lastFtN   = -1;
  int        ftPeriod  = 0;
  logic [15:0] gameMask = '0;

  vga_timing_gen_if ifA ();
  vga_timing_gen_if ifB ();
  vga_timing_gen_if ifC ();

  vga_timing_gen dutA (
    .clk (clk),
    .rst (rstA),
    .vga (ifA)
  );

  vga_timing_gen #(
    .CLK_DIV(4), .H_TOTAL(10), .H_SYNC(2), .H_ACT_START(3), .H_ACT_END(8),
    .V_TOTAL(4), .V_SYNC(1), .V_ACT_START(1), .V_ACT_END(3), .FRAMES_PER_TICK(3)
  ) dutB (
    .clk (clk),
    .rst (rstB),
    .vga (ifB)
  );

  vga_timing_gen #(
    .CLK_DIV(4), .H_TOTAL(10), .H_SYNC(2), .H_ACT_START(3), .H_ACT_END(8),
    .V_TOTAL(4), .V_SYNC(1), .V_ACT_START(1), .V_ACT_END(3), .FRAMES_PER_TICK(1)
  ) dutC (
    .clk (clk),
    .rst (rstB),
    .vga (ifC)
  );

  always #5 clk = ~clk;

  // Count rising edges since each reset release; the model works from this count alone.
  always @(posedge clk or posedge rstA) begin
    if (rstA) nA <= 0;
    else      nA <= nA + 1;
  end

  always @(posedge clk or posedge rstB) begin
    if (rstB) nB <= 0;
    else      nB <= nB + 1;
  end

  // Expected outputs after n edges: pixel k = (n-1)/div, position and ticks by plain division.
  function automatic logic [25:0] modelOut(input int n, input bit inRst, input int div,
                                           input int ht, input int hs, input int has, input int hae,
                                           input int vt, input int vs, input int vas, input int vae,
                                           input int fpt);
    int k, h, v, f;
    bit pe, ft, gt, br;
    if (inRst) return '0;
    k  = (n >= 1) ? (n - 1) / div : 0;
    pe = (n >= div) && (n % div == 0);
    h  = k % ht;
    v  = (k / ht) % vt;
    f  = k / (ht * vt);
    ft = (n >= 1) && ((n - 1) % div == 0) && (k > 0) && (h == 0) && (v == 0);
    gt = ft && (f % fpt == 0);
    br = (h >= has) && (h < hae) && (v >= vas) && (v < vae);
    return {pe, 10'(h), 10'(v), (h >= hs), (v >= vs), br, ft, gt};
  endfunction

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    logic [25:0] expA, expB, expC, gotA, gotB, gotC;
    expA = modelOut(nA, rstA, 4, 800, 96, 144, 784, 525, 2, 35, 515, 6);
    expB = modelOut(nB, rstB, 4, 10, 2, 3, 8, 4, 1, 1, 3, 3);
    expC = modelOut(nB, rstB, 4, 10, 2, 3, 8, 4, 1, 1, 3, 1);
    gotA = {ifA.pclk_en, ifA.hCount, ifA.vCount, ifA.hSync, ifA.vSync, ifA.bright, ifA.frame_tick, ifA.game_tick};
    gotB = {ifB.pclk_en, ifB.hCount, ifB.vCount, ifB.hSync, ifB.vSync, ifB.bright, ifB.frame_tick, ifB.game_tick};
    gotC = {ifC.pclk_en, ifC.hCount, ifC.vCount, ifC.hSync, ifC.vSync, ifC.bright, ifC.frame_tick, ifC.game_tick};
    total += 3;
    if (gotA !== expA) begin
      bad++;
      $display("[TB] FAIL modelA n=%0d got %h expected %h", nA, gotA, expA);
    end
    if (gotB !== expB) begin
      bad++;
      $display("[TB] FAIL modelB n=%0d got %h expected %h", nB, gotB, expB);
    end
    if (gotC !== expC) begin
      bad++;
      $display("[TB] FAIL modelC n=%0d got %h expected %h", nB, gotC, expC);
    end
  end

  // Record frame ticks of the shrunken instance: which ones carried game_tick and their spacing.
  always @(negedge clk) begin
    if (!rstB && ifB.frame_tick) begin
      ftCount++;
      if (ftCount < 16 && ifB.game_tick) gameMask[ftCount] = 1'b1;
      if (lastFtN >= 0) ftPeriod = nB - lastFtN;
      lastFtN = nB;
    end
  end

  task automatic applyStimulus(input bit selB, input bit rstVal);
    @(negedge clk);
    #1;
    if (selB) rstB = rstVal;
    else      rstA = rstVal;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic stepEdges(input int cnt);
    repeat (cnt) @(negedge clk);
  endtask

  task automatic waitPos(input bit selB, input int h, input int v, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      if (selB) begin
        if (ifB.hCount == 10'(h) && ifB.vCount == 10'(v)) break;
      end else begin
        if (ifA.hCount == 10'(h) && ifA.vCount == 10'(v)) break;
      end
    end
    if (i == limit) begin
      total++;
      bad++;
      $display("[TB] FAIL timeout waiting for (%0d,%0d) on %s", h, v, selB ? "B" : "A");
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] starting vga_timing_gen bench");
    stepEdges(3);

    // Full-size instance: reset values and first pixel enable.
    applyStimulus(1'b0, 1'b0);
    checkOutput("A reset hCount", 32'(ifA.hCount), 0);
    checkOutput("A reset vCount", 32'(ifA.vCount), 0);
    checkOutput("A reset syncs/bright", 32'({ifA.hSync, ifA.vSync, ifA.bright}), 0);
    checkOutput("A reset ticks", 32'({ifA.pclk_en, ifA.frame_tick, ifA.game_tick}), 0);
    stepEdges(3);
    checkOutput("A pclk_en edge3", 32'(ifA.pclk_en), 0);
    stepEdges(1);
    checkOutput("A pclk_en edge4", 32'(ifA.pclk_en), 1);
    checkOutput("A hCount edge4", 32'(ifA.hCount), 0);
    stepEdges(1);
    checkOutput("A hCount edge5", 32'(ifA.hCount), 1);

    // One line: hSync edge and line wrap.
    waitPos(1'b0, 95, 0, 500);
    checkOutput("A hSync at 95", 32'(ifA.hSync), 0);
    waitPos(1'b0, 96, 0, 20);
    checkOutput("A hSync at 96", 32'(ifA.hSync), 1);
    waitPos(1'b0, 799, 0, 3000);
    checkOutput("A vCount at 799", 32'(ifA.vCount), 0);
    waitPos(1'b0, 0, 1, 20);
    checkOutput("A hCount after wrap", 32'(ifA.hCount), 0);
    checkOutput("A vCount after wrap", 32'(ifA.vCount), 1);
    checkOutput("A no frame_tick on line wrap", 32'(ifA.frame_tick), 0);
    checkOutput("A vSync line 1", 32'(ifA.vSync), 0);

    // Shrunken instance: active window boundaries and vSync.
    applyStimulus(1'b1, 1'b0);
    checkOutput("B vSync line 0", 32'(ifB.vSync), 0);
    waitPos(1'b1, 2, 1, 200);
    checkOutput("B bright (2,1)", 32'(ifB.bright), 0);
    checkOutput("B vSync line 1", 32'(ifB.vSync), 1);
    waitPos(1'b1, 3, 1, 20);
    checkOutput("B bright (3,1)", 32'(ifB.bright), 1);
    waitPos(1'b1, 7, 2, 100);
    checkOutput("B bright (7,2)", 32'(ifB.bright), 1);
    waitPos(1'b1, 8, 2, 20);
    checkOutput("B bright (8,2)", 32'(ifB.bright), 0);
    waitPos(1'b1, 3, 3, 100);
    checkOutput("B bright (3,3)", 32'(ifB.bright), 0);

    // Ten frames: game ticks on the 3rd, 6th and 9th frame tick, 160 clocks apart.
    for (int i = 0; i < 2000 && ftCount < 10; i++) @(negedge clk);
    checkOutput("B frame tick count", 32'(ftCount), 10);
    checkOutput("B game tick pattern", 32'(gameMask), 32'h0248);
    checkOutput("B frame period", 32'(ftPeriod), 160);

    // Mid-frame, mid-divider reset.
    waitPos(1'b1, 5, 2, 200);
    stepEdges(1);
    #1;
    rstB = 1'b1;
    #1;
    checkOutput("B reset counts", 32'({ifB.hCount, ifB.vCount}), 0);
    checkOutput("B reset flags", 32'({ifB.pclk_en, ifB.hSync, ifB.vSync, ifB.bright, ifB.frame_tick, ifB.game_tick}), 0);
    stepEdges(3);
    applyStimulus(1'b1, 1'b0);
    checkOutput("B restart hCount", 32'(ifB.hCount), 0);
    stepEdges(4);
    checkOutput("B restart pclk_en edge4", 32'(ifB.pclk_en), 1);
    checkOutput("B restart hCount edge4", 32'(ifB.hCount), 0);
    stepEdges(1);
    checkOutput("B restart hCount edge5", 32'(ifB.hCount), 1);
    stepEdges(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
